// File: rtl/sequence_display.sv
// sequence_display: plays the stored colour sequence on the board LEDs.
// A start pulse reads each item from the sequence memory, lights its LED
// for ON_CYC cycles and then blanks it for GAP_CYC cycles. The controller
// receives a done pulse when the whole sequence has been shown.
module sequence_display #(
    parameter int DEPTH  = 16,
    parameter int T_BASE = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic [4:0]               length,
    input  logic [1:0]               speed,
    output logic                     rd_en,
    output logic [$clog2(DEPTH)-1:0] rd_addr,
    input  logic [1:0]               rd_data,
    output logic [3:0]               led,
    output logic                     busy,
    output logic                     done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(4 * T_BASE + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        ON    = 3'd3,
        GAP   = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t          state_r;
    logic [AW-1:0]   idx_r;
    logic [4:0]      len_r;
    logic [1:0]      speed_r;
    logic [CW-1:0]   cnt_r;
    logic [3:0]      led_r;
    logic            rd_en_r;
    logic            busy_r;
    logic            done_r;

    // Lit duration of one item: slower speeds get more base units.
    function automatic logic [CW-1:0] on_cycles(input logic [1:0] s);
        on_cycles = CW'(T_BASE * (32'd4 - {30'd0, s}));
    endfunction

    // One-hot LED pattern for a colour code.
    function automatic logic [3:0] onehot(input logic [1:0] c);
        onehot = 4'b0001 << c;
    endfunction

    // Playback FSM; every output is a register updated with the next state.
    // The led register doubles as the latched item (held in one-hot form).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            idx_r   <= '0;
            len_r   <= 5'd0;
            speed_r <= 2'd0;
            cnt_r   <= '0;
            led_r   <= 4'd0;
            rd_en_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            rd_en_r <= 1'b0;
            done_r  <= 1'b0;
            if (abort && (state_r != IDLE)) begin
                state_r <= IDLE;
                led_r   <= 4'd0;
                busy_r  <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        led_r <= 4'd0;
                        if (start) begin
                            len_r   <= (length > 5'(DEPTH)) ? 5'(DEPTH) : length;
                            speed_r <= speed;
                            idx_r   <= '0;
                            busy_r  <= 1'b1;
                            if (length == 5'd0) begin
                                state_r <= DONE;
                                done_r  <= 1'b1;
                            end else begin
                                state_r <= FETCH;
                                rd_en_r <= 1'b1;
                            end
                        end else begin
                            busy_r <= 1'b0;
                        end
                    end
                    FETCH: begin
                        state_r <= WAIT;
                    end
                    WAIT: begin
                        led_r   <= onehot(rd_data);
                        cnt_r   <= on_cycles(speed_r);
                        state_r <= ON;
                    end
                    ON: begin
                        if (cnt_r == CW'(1)) begin
                            led_r   <= 4'd0;
                            cnt_r   <= on_cycles(speed_r) >> 1;
                            state_r <= GAP;
                        end else begin
                            cnt_r <= cnt_r - CW'(1);
                        end
                    end
                    GAP: begin
                        if (cnt_r == CW'(1)) begin
                            cnt_r <= '0;
                            if ((5'(idx_r) + 5'd1) == len_r) begin
                                state_r <= DONE;
                                done_r  <= 1'b1;
                            end else begin
                                idx_r   <= idx_r + AW'(1);
                                state_r <= FETCH;
                                rd_en_r <= 1'b1;
                            end
                        end else begin
                            cnt_r <= cnt_r - CW'(1);
                        end
                    end
                    DONE: begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                    default: begin
                        state_r <= IDLE;
                        led_r   <= 4'd0;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rd_en   = rd_en_r;
    assign rd_addr = idx_r;
    assign led     = led_r;
    assign busy    = busy_r;
    assign done    = done_r;

endmodule
